// File: rtl/microwave_ctrl.sv
// microwave_ctrl: front-panel FSM driving the countdown timer, magnetron, buzzer.
// Optional MWC_DOOR_LOCK_EN adds door_lock and aborts the cook on door open.
module microwave_ctrl #(
  parameter int BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       keypad_valid,
  input  logic [3:0] keypad_digit,
  input  logic       startn,
  input  logic       stopn,
  input  logic       cancn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       tmr_loadn,
  output logic [3:0] tmr_data,
  output logic       tmr_en,
  output logic       tmr_clrn,
  output logic       mag_on,
  output logic       buzzer,
`ifdef MWC_DOOR_LOCK_EN
  output logic       door_lock,
`endif
  output logic [2:0] state
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [1:0]    ndig;
  logic [BW-1:0] beep;
  logic          start_p;
  logic          stop_p;
  logic          canc_p;
  logic          start_e;
  logic          stop_e;
  logic          canc_e;
  logic          dig_ok;
  logic          clr;

  assign start_e = start_p & ~startn;
  assign stop_e  = stop_p & ~stopn;
  assign canc_e  = canc_p & ~cancn;
  assign state   = st;

  // any button edge outranks a digit in the same cycle
  assign dig_ok = keypad_valid & (keypad_digit <= 4'd9)
                & (ndig != 2'd3)
                & ~(start_e | stop_e | canc_e)
                & ((st == IDLE) | (st == SET));

  always_comb begin
    nxt = st;
    clr = 1'b0;
    unique case (st)
      IDLE: begin
        if (dig_ok) nxt = SET;
      end
      SET: begin
        if (canc_e) begin
          nxt = IDLE;
          clr = 1'b1;
        end else if (start_e & door_closed & ~timer_zero) begin
          nxt = COOK;
        end
      end
      COOK: begin
        if (canc_e) begin
          nxt = IDLE;
          clr = 1'b1;
        end else if (stop_e) begin
          nxt = PAUSE;
        end else if (~door_closed) begin
`ifdef MWC_DOOR_LOCK_EN
          nxt = IDLE;
          clr = 1'b1;
`else
          nxt = PAUSE;
`endif
        end else if (timer_zero) begin
          nxt = DONE;
        end
      end
      PAUSE: begin
        if (canc_e | stop_e) begin
          nxt = IDLE;
          clr = 1'b1;
        end else if (start_e & door_closed) begin
          nxt = COOK;
        end
      end
      DONE: begin
        if (canc_e | stop_e | ~door_closed | (beep == BW'(1)))
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      st        <= IDLE;
      ndig      <= 2'd0;
      beep      <= '0;
      start_p   <= 1'b1;
      stop_p    <= 1'b1;
      canc_p    <= 1'b1;
      tmr_loadn <= 1'b1;
      tmr_data  <= 4'd0;
      tmr_en    <= 1'b0;
      tmr_clrn  <= 1'b0;
      mag_on    <= 1'b0;
      buzzer    <= 1'b0;
`ifdef MWC_DOOR_LOCK_EN
      door_lock <= 1'b0;
`endif
    end else begin
      st        <= nxt;
      start_p   <= startn;
      stop_p    <= stopn;
      canc_p    <= cancn;
      tmr_loadn <= ~dig_ok;
      tmr_clrn  <= ~clr;
      tmr_en    <= (nxt == COOK);
      mag_on    <= (nxt == COOK) & door_closed;
      buzzer    <= (nxt == DONE);
`ifdef MWC_DOOR_LOCK_EN
      door_lock <= (nxt == COOK);
`endif
      if (dig_ok) tmr_data <= keypad_digit;
      if (nxt == IDLE) ndig <= 2'd0;
      else if (dig_ok) ndig <= ndig + 2'd1;
      if ((st != DONE) && (nxt == DONE)) beep <= BW'(BEEP_CYCLES);
      else if (st == DONE) beep <= beep - BW'(1);
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed scenarios plus random stimulus
// checked against a behavioural model of the panel rules.
module tb_microwave_ctrl;

  localparam int BEEP = 8;
  localparam int S_IDLE = 0;
  localparam int S_SET = 1;
  localparam int S_COOK = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE = 4;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       keypad_valid = 1'b0;
  logic [3:0] keypad_digit = 4'd0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       cancn = 1'b1;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic       tmr_loadn;
  logic [3:0] tmr_data;
  logic       tmr_en;
  logic       tmr_clrn;
  logic       mag_on;
  logic       buzzer;
  logic [2:0] state;
`ifdef MWC_DOOR_LOCK_EN
  logic       door_lock;
`endif

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_st = S_IDLE;
  int m_nd = 0;
  int m_beep = 0;
  bit mp_s = 1;
  bit mp_p = 1;
  bit mp_c = 1;
  int e_st = S_IDLE;
  bit e_loadn = 1;
  int e_data = 0;
  bit e_en = 0;
  bit e_clrn = 0;
  bit e_mag = 0;
  bit e_buz = 0;

  microwave_ctrl #(.BEEP_CYCLES(BEEP)) dut (
    .clk(clk),
    .clrn(clrn),
    .keypad_valid(keypad_valid),
    .keypad_digit(keypad_digit),
    .startn(startn),
    .stopn(stopn),
    .cancn(cancn),
    .door_closed(door_closed),
    .timer_zero(timer_zero),
    .tmr_loadn(tmr_loadn),
    .tmr_data(tmr_data),
    .tmr_en(tmr_en),
    .tmr_clrn(tmr_clrn),
    .mag_on(mag_on),
    .buzzer(buzzer),
`ifdef MWC_DOOR_LOCK_EN
    .door_lock(door_lock),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // advance model from current inputs, then one clock edge
  task automatic cyc();
    bit se, pe, ce, dopen, acc, clr;
    int ns;
    if (!clrn) begin
      m_st = S_IDLE; m_nd = 0; m_beep = 0;
      mp_s = 1; mp_p = 1; mp_c = 1;
      e_loadn = 1; e_data = 0; e_en = 0;
      e_clrn = 0; e_mag = 0; e_buz = 0;
    end else begin
      se = mp_s && !startn;
      pe = mp_p && !stopn;
      ce = mp_c && !cancn;
      dopen = !door_closed;
      clr = 0;
      ns = m_st;
      acc = keypad_valid && keypad_digit < 10 && m_nd < 3
            && !se && !pe && !ce
            && (m_st == S_IDLE || m_st == S_SET);
      if (m_st == S_SET) begin
        if (ce) begin ns = S_IDLE; clr = 1; end
        else if (se && door_closed && !timer_zero) ns = S_COOK;
      end else if (m_st == S_COOK) begin
        if (ce) begin ns = S_IDLE; clr = 1; end
        else if (pe) ns = S_PAUSE;
        else if (dopen) begin
`ifdef MWC_DOOR_LOCK_EN
          ns = S_IDLE; clr = 1;
`else
          ns = S_PAUSE;
`endif
        end else if (timer_zero) begin
          ns = S_DONE; m_beep = BEEP;
        end
      end else if (m_st == S_PAUSE) begin
        if (ce || pe) begin ns = S_IDLE; clr = 1; end
        else if (se && door_closed) ns = S_COOK;
      end else if (m_st == S_DONE) begin
        if (ce || pe || dopen || m_beep == 1) ns = S_IDLE;
        else m_beep = m_beep - 1;
      end
      if (acc) begin
        m_nd++;
        e_data = int'(keypad_digit);
        if (m_st == S_IDLE) ns = S_SET;
      end
      if (ns == S_IDLE) m_nd = 0;
      m_st = ns;
      e_loadn = !acc;
      e_clrn = !clr;
      e_en = (ns == S_COOK);
      e_mag = (ns == S_COOK) && door_closed;
      e_buz = (ns == S_DONE);
      mp_s = startn; mp_p = stopn; mp_c = cancn;
    end
    e_st = m_st;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 0; cyc();
    clrn = 1; cyc();
  endtask

  task automatic goto_cook();
    do_reset();
    door_closed = 1; timer_zero = 0;
    keypad_valid = 1; keypad_digit = 4'd1; cyc();
    keypad_valid = 0; startn = 0; cyc();
    startn = 1; cyc();
  endtask

  task automatic test_reset();
    clrn = 0; cyc(); cyc();
    n_vec++;
    if ({state, tmr_loadn, tmr_data, tmr_en, tmr_clrn, mag_on, buzzer}
        !== {3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_vals st=%0d ld=%b d=%0d en=%b clr=%b mag=%b bz=%b exp 0 1 0 0 0 0 0",
               state, tmr_loadn, tmr_data, tmr_en, tmr_clrn, mag_on, buzzer);
    end
    clrn = 1; cyc();
    n_vec++;
    if (tmr_clrn !== 1'b1 || state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release clr=%b st=%0d exp 1 0", tmr_clrn, state);
    end
  endtask

  task automatic test_digits_cook();
    logic [3:0] dg [4] = '{4'd0, 4'd3, 4'd0, 4'd5};
    for (int i = 0; i < 4; i++) begin
      keypad_valid = 1; keypad_digit = dg[i]; cyc();
      n_vec++;
      if (tmr_loadn !== (i == 3) || state !== 3'd1
          || (i < 3 && tmr_data !== dg[i])) begin
        n_err++;
        $display("FAIL digit%0d ld=%b d=%0d st=%0d exp ld=%b d=%0d st=1",
                 i, tmr_loadn, tmr_data, state, i == 3, dg[i]);
      end
    end
    keypad_valid = 0; startn = 0; cyc();
    n_vec++;
    if (state !== 3'd2 || tmr_en !== 1'b1 || mag_on !== 1'b1) begin
      n_err++;
      $display("FAIL start_cook st=%0d en=%b mag=%b exp 2 1 1", state, tmr_en, mag_on);
    end
    startn = 1; cyc();
  endtask

  task automatic test_door();
    door_closed = 0; cyc();
`ifdef MWC_DOOR_LOCK_EN
    n_vec++;
    if (state !== 3'd0 || tmr_clrn !== 1'b0 || mag_on !== 1'b0 || door_lock !== 1'b0) begin
      n_err++;
      $display("FAIL door_fault st=%0d clr=%b mag=%b lock=%b exp 0 0 0 0",
               state, tmr_clrn, mag_on, door_lock);
    end
    door_closed = 1; cyc();
    n_vec++;
    if (tmr_clrn !== 1'b1) begin
      n_err++;
      $display("FAIL door_clr_pulse clr=%b exp 1", tmr_clrn);
    end
`else
    n_vec++;
    if (state !== 3'd3 || mag_on !== 1'b0 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL door_pause st=%0d mag=%b en=%b exp 3 0 0", state, mag_on, tmr_en);
    end
    door_closed = 1; cyc();
    startn = 0; cyc();
    n_vec++;
    if (state !== 3'd2 || mag_on !== 1'b1 || tmr_en !== 1'b1) begin
      n_err++;
      $display("FAIL door_resume st=%0d mag=%b en=%b exp 2 1 1", state, mag_on, tmr_en);
    end
    startn = 1; cyc();
`endif
  endtask

  task automatic test_done();
    int cnt;
    goto_cook();
    timer_zero = 1; cyc();
    timer_zero = 0;
    n_vec++;
    if (state !== 3'd4 || buzzer !== 1'b1 || tmr_en !== 1'b0 || mag_on !== 1'b0) begin
      n_err++;
      $display("FAIL done_entry st=%0d bz=%b en=%b mag=%b exp 4 1 0 0",
               state, buzzer, tmr_en, mag_on);
    end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (buzzer !== 1'b1) break;
      cnt++;
    end
    n_vec++;
    if (cnt != BEEP || state !== 3'd0 || tmr_clrn !== 1'b1) begin
      n_err++;
      $display("FAIL done_beep cycles=%0d st=%0d clr=%b exp %0d 0 1",
               cnt, state, tmr_clrn, BEEP);
    end
  endtask

  task automatic test_cancel_start();
    do_reset();
    keypad_valid = 1; keypad_digit = 4'd2; cyc();
    keypad_valid = 0; cancn = 0; startn = 0; cyc();
    n_vec++;
    if (state !== 3'd0 || tmr_clrn !== 1'b0 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_win st=%0d clr=%b en=%b exp 0 0 0", state, tmr_clrn, tmr_en);
    end
    cancn = 1; startn = 1; cyc();
    n_vec++;
    if (state !== 3'd0 || tmr_clrn !== 1'b1) begin
      n_err++;
      $display("FAIL cancel_after st=%0d clr=%b exp 0 1", state, tmr_clrn);
    end
    for (int i = 0; i < 3; i++) begin
      keypad_valid = 1; keypad_digit = 4'(i + 7); cyc();
      n_vec++;
      if (tmr_loadn !== 1'b0 || tmr_data !== 4'(i + 7)) begin
        n_err++;
        $display("FAIL ndig_clear%0d ld=%b d=%0d exp 0 %0d", i, tmr_loadn, tmr_data, i + 7);
      end
    end
    keypad_valid = 0; cyc();
  endtask

  task automatic test_invalid();
    do_reset();
    keypad_valid = 1; keypad_digit = 4'd1; cyc();
    keypad_digit = 4'd12; cyc();
    n_vec++;
    if (tmr_loadn !== 1'b1 || state !== 3'd1) begin
      n_err++;
      $display("FAIL digit12 ld=%b st=%0d exp 1 1", tmr_loadn, state);
    end
    keypad_valid = 0; door_closed = 0; startn = 0; cyc();
    n_vec++;
    if (state !== 3'd1 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL start_door_open st=%0d en=%b exp 1 0", state, tmr_en);
    end
    startn = 1; door_closed = 1; cyc();
  endtask

  task automatic test_reset_mid_cook();
    goto_cook();
    clrn = 0; cyc();
    n_vec++;
    if ({state, tmr_loadn, tmr_data, tmr_en, tmr_clrn, mag_on, buzzer}
        !== {3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_cook st=%0d ld=%b d=%0d en=%b clr=%b mag=%b bz=%b exp 0 1 0 0 0 0 0",
               state, tmr_loadn, tmr_data, tmr_en, tmr_clrn, mag_on, buzzer);
    end
    clrn = 1; cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clrn = ($urandom_range(0, 199) != 0);
      keypad_valid = $urandom_range(0, 1);
      keypad_digit = 4'($urandom_range(0, 15));
      startn = ($urandom_range(0, 3) != 0);
      stopn = ($urandom_range(0, 7) != 0);
      cancn = ($urandom_range(0, 9) != 0);
      door_closed = ($urandom_range(0, 9) != 0);
      timer_zero = ($urandom_range(0, 5) == 0);
      cyc();
      n_vec++;
      if (state !== 3'(e_st)) begin
        n_err++;
        $display("FAIL rnd_state c=%0d got %0d exp %0d", c, state, e_st);
      end
      n_vec++;
      if (tmr_loadn !== e_loadn || (!e_loadn && tmr_data !== 4'(e_data))) begin
        n_err++;
        $display("FAIL rnd_load c=%0d got %b/%0d exp %b/%0d",
                 c, tmr_loadn, tmr_data, e_loadn, e_data);
      end
      n_vec++;
      if ({tmr_en, tmr_clrn, mag_on, buzzer} !== {e_en, e_clrn, e_mag, e_buz}) begin
        n_err++;
        $display("FAIL rnd_outs c=%0d en/clr/mag/bz got %b%b%b%b exp %b%b%b%b",
                 c, tmr_en, tmr_clrn, mag_on, buzzer, e_en, e_clrn, e_mag, e_buz);
      end
`ifdef MWC_DOOR_LOCK_EN
      n_vec++;
      if (door_lock !== (e_st == S_COOK)) begin
        n_err++;
        $display("FAIL rnd_lock c=%0d got %b exp %b", c, door_lock, e_st == S_COOK);
      end
`endif
    end
    clrn = 1; keypad_valid = 0;
    startn = 1; stopn = 1; cancn = 1;
    door_closed = 1; timer_zero = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_digits_cook();
    test_door();
    test_done();
    test_cancel_start();
    test_invalid();
    test_reset_mid_cook();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
